// File: rtl/graycounter_sequencer.sv
// graycounter_sequencer: drives a Gray counter with pulses until its decoded count hits a target,
// supervising single-bit steps and flagging a stall after a full wrap without a match.
module graycounter_sequencer #(
    parameter int HALF = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] count,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             err_step,
    output logic             err_stall,
    output logic [CNT_W-1:0] steps
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] div, div_nx;
    logic pulse_q, pulse_nx, stall_nx, accept, term, multi;
    logic [CNT_W-1:0] cnt_q, cnt_prev, tgt, tgt_nx, steps_nx, bin, diff;
    always_comb begin
        bin = '0;
        for (int i = 0; i < CNT_W; i++) bin[i] = ^(cnt_q >> i);
    end
    assign diff   = cnt_q ^ cnt_prev;
    assign multi  = (diff & (diff - 1'b1)) != '0;
    assign accept = state == IDLE && start && !stop;
    assign term   = div == 8'(HALF - 1);
    assign pulse  = pulse_q & rst;
    assign busy   = state == RUN;
    assign done   = state == DONE;
    always_comb begin
        state_nx = state;
        div_nx   = div;
        pulse_nx = pulse_q;
        tgt_nx   = tgt;
        steps_nx = steps;
        stall_nx = err_stall;
        case (state)
            IDLE: begin
                div_nx   = '0;
                pulse_nx = 1'b0;
                if (accept) begin
                    state_nx = RUN;
                    tgt_nx   = target;
                    steps_nx = '0;
                    stall_nx = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                    pulse_nx = 1'b0;
                    div_nx   = '0;
                end else if (term) begin
                    div_nx = '0;
                    // checks happen only in the low phase, just before a rising edge
                    if (pulse_q) pulse_nx = 1'b0;
                    else if (bin == tgt) state_nx = DONE;
                    else if (&steps) begin
                        stall_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        pulse_nx = 1'b1;
                        steps_nx = steps + 1'b1;
                    end
                end else div_nx = div + 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div       <= '0;
            pulse_q   <= 1'b0;
            tgt       <= '0;
            steps     <= '0;
            err_stall <= 1'b0;
            err_step  <= 1'b0;
            cnt_q     <= '0;
            cnt_prev  <= '0;
        end else begin
            state     <= state_nx;
            div       <= div_nx;
            pulse_q   <= pulse_nx;
            tgt       <= tgt_nx;
            steps     <= steps_nx;
            err_stall <= stall_nx;
            err_step  <= multi | (err_step & ~accept);
            cnt_q     <= count;
            cnt_prev  <= cnt_q;
        end
    end
endmodule

// File: tb/tb_graycounter_sequencer.sv
// tb_graycounter_sequencer: directed bench with a behavioural Gray counter model around the sequencer.
module tb_graycounter_sequencer;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] target = '0, count;
    logic pulse, busy, done, err_step, err_stall;
    logic [3:0] steps;
    logic load = 1'b1, frozen = 1'b0, pulse_d = 1'b0;
    logic [3:0] load_val = '0, mbin = '0;
    int edges = 0, dones = 0, checks = 0, errors = 0, e0, d0;

    graycounter_sequencer #(.HALF(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .target(target), .count(count),
        .pulse(pulse), .busy(busy), .done(done), .err_step(err_step), .err_stall(err_stall),
        .steps(steps)
    );

    always #5 clk = ~clk;
    assign count = mbin ^ (mbin >> 1);

    // counter model: advances once per pulse rising edge, visible one clk later
    always @(posedge clk) begin
        pulse_d <= pulse;
        if (load) mbin <= load_val;
        else if (pulse && !pulse_d && !frozen) mbin <= mbin + 4'd1;
        if (pulse && !pulse_d) edges <= edges + 1;
        if (done) dones <= dones + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [3:0] v);
        load = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
        tick();
        tick();
    endtask

    task automatic go(input logic [3:0] t);
        e0 = edges;
        d0 = dones;
        target = t;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) tick();
        chk(tag, done, 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pulse", pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_step", err_step, 0);
        chk("rst_err_stall", err_stall, 0);
        chk("rst_steps", steps, 0);
        rst = 1'b1;
        load = 1'b0;
        tick();

        go(4'd5);
        chk("t5_busy", busy, 1);
        wait_done("t5_done");
        chk("t5_busy_low", busy, 0);
        chk("t5_steps", steps, 5);
        chk("t5_edges", edges - e0, 5);
        chk("t5_count", count, 4'b0111);
        tick();
        chk("t5_done_once", done, 0);
        chk("t5_dones", dones - d0, 1);

        preset(4'd3);
        go(4'd3);
        chk("zl_busy", busy, 1);
        tick();
        chk("zl_done_early", done, 0);
        tick();
        chk("zl_done", done, 1);
        chk("zl_steps", steps, 0);
        chk("zl_edges", edges - e0, 0);
        chk("zl_pulse", pulse, 0);

        preset(4'd14);
        go(4'd1);
        wait_done("wrap_done");
        chk("wrap_steps", steps, 3);
        chk("wrap_edges", edges - e0, 3);

        frozen = 1'b1;
        preset(4'd0);
        go(4'd9);
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("stall_idle", busy, 0);
        chk("stall_flag", err_stall, 1);
        chk("stall_edges", edges - e0, 15);
        chk("stall_steps", steps, 15);
        chk("stall_no_done", dones - d0, 0);
        frozen = 1'b0;

        preset(4'd0);
        go(4'd12);
        chk("abort_stall_clr", err_stall, 0);
        for (int i = 0; i < 100 && edges - e0 < 4; i++) tick();
        chk("abort_edges", edges - e0, 4);
        stop = 1'b1;
        start = 1'b1;
        target = 4'd3;
        tick();
        stop = 1'b0;
        start = 1'b0;
        chk("abort_pulse", pulse, 0);
        chk("abort_busy", busy, 0);
        chk("abort_steps", steps, 4);
        tick();
        chk("abort_start_ign", busy, 0);
        chk("abort_no_done", dones - d0, 0);

        preset(4'd0);
        go(4'd12);
        for (int i = 0; i < 100 && edges - e0 < 1; i++) tick();
        chk("arst_pulse_hi", pulse, 1);
        rst = 1'b0;
        #1;
        chk("arst_pulse", pulse, 0);
        chk("arst_busy", busy, 0);
        chk("arst_steps", steps, 0);
        tick();
        rst = 1'b1;
        tick();

        preset(4'd1);
        go(4'd7);
        load = 1'b1;
        load_val = 4'd5;
        tick();
        load = 1'b0;
        tick();
        chk("step_pre", err_step, 0);
        tick();
        chk("step_set", err_step, 1);
        chk("step_running", busy, 1);
        wait_done("step_done");
        chk("step_steps", steps, 2);
        chk("step_sticky", err_step, 1);
        tick();
        go(4'd7);
        chk("step_clear", err_step, 0);
        wait_done("step_zl_done");
        chk("step_zl_steps", steps, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
